rf_channel_monitor: RTL and testbench

- Parametrised successor to the fixed 8-tile ADC/DAC monitor.
- Registers NUM_CH ADC AXI-Stream inputs and NUM_CH DAC AXI-Stream outputs with real tready handling.
- Muxes one selected ADC or DAC channel onto per-lane debug lines.
- Adds a threshold-triggered snapshot buffer with a synchronous readback port. Sits between the RF data converter and user DSP/ILA logic.

---
 rtl/rf_channel_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_rf_channel_monitor.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_channel_monitor.sv
// rf_channel_monitor
//   Registers NUM_CH ADC AXI-Stream inputs and NUM_CH DAC AXI-Stream outputs.
//   Muxes one selected channel onto the debug lines.
//   Runs a threshold-triggered snapshot buffer on lane 0 of the monitored stream.
//
// Ports (W = NUM_LANES*SAMPLE_W):
//   clock_i, reset_i            single clock, synchronous active-high reset
//   adc_in_tvalid_i/tdata_i     ADC streams in, channel c at [c*W +: W]
//   adc_in_tready_o             ADC ready, all ones once running
//   adc_data_o                  registered ADC words
//   dac_data_i                  DAC source words
//   dac_out_tvalid/tdata_o      DAC streams out
//   dac_out_tready_i            DAC ready from downstream
//   monitor_select_i            channel to monitor
//   monitor_source_i            0 = ADC, 1 = DAC
//   monitor_lines_o             monitored word, lane k at [k*SAMPLE_W +: SAMPLE_W]
//   cap_arm_i, cap_force_i      capture arm pulse, forced trigger
//   cap_threshold_i             signed trigger level
//   cap_busy_o                  high in ARMED or CAPTURE
//   cap_done_o                  high in DONE
//   cap_count_o                 beats stored
//   cap_rd_addr_i, cap_rd_data_o  synchronous readback, 1-cycle latency
//
// Capture FSM
//   state   | meaning
//   IDLE    | waiting for cap_arm
//   ARMED   | watching lane 0 for an upward threshold crossing or cap_force
//   CAPTURE | storing one monitored beat per valid until the buffer is full
//   DONE    | buffer full and frozen
module rf_channel_monitor #(
  parameter int NUM_CH    = 8,
  parameter int NUM_LANES = 8,
  parameter int SAMPLE_W  = 16,
  parameter int DEPTH     = 16,
  parameter int SEL_W     = 3,
  parameter int ADDR_W    = 4
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic [NUM_CH-1:0]                    adc_in_tvalid_i,
  input  logic [NUM_CH*NUM_LANES*SAMPLE_W-1:0] adc_in_tdata_i,
  output logic [NUM_CH-1:0]                    adc_in_tready_o,
  output logic [NUM_CH*NUM_LANES*SAMPLE_W-1:0] adc_data_o,
  input  logic [NUM_CH*NUM_LANES*SAMPLE_W-1:0] dac_data_i,
  output logic [NUM_CH-1:0]                    dac_out_tvalid_o,
  output logic [NUM_CH*NUM_LANES*SAMPLE_W-1:0] dac_out_tdata_o,
  input  logic [NUM_CH-1:0]                    dac_out_tready_i,
  input  logic [SEL_W-1:0]                     monitor_select_i,
  input  logic                                 monitor_source_i,
  output logic [NUM_LANES*SAMPLE_W-1:0]        monitor_lines_o,
  input  logic                                 cap_arm_i,
  input  logic                                 cap_force_i,
  input  logic [SAMPLE_W-1:0]                  cap_threshold_i,
  output logic                                 cap_busy_o,
  output logic                                 cap_done_o,
  output logic [ADDR_W:0]                      cap_count_o,
  input  logic [ADDR_W-1:0]                    cap_rd_addr_i,
  output logic [NUM_LANES*SAMPLE_W-1:0]        cap_rd_data_o
);

  localparam int W = NUM_LANES * SAMPLE_W;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_e;

  // live_q is 0 for the first cycle after reset and 1 afterwards; it drives
  // both adc_in_tready and dac_out_tvalid, which share that timing.
  logic                  live_q;
  logic [NUM_CH-1:0]     acc_q;
  logic [NUM_CH*W-1:0]   adc_data_q;
  logic [NUM_CH*W-1:0]   dac_tdata_q;
  logic [W-1:0]          mon_lines_q, mon_lines_d;
  logic                  mon_valid_q, mon_valid_d;
  logic [SEL_W-1:0]      sel_eff;

  state_e                state_q, state_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [SAMPLE_W-1:0]   prev_q, prev_d;
  logic                  prev_ok_q, prev_ok_d;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [SAMPLE_W-1:0]   lane0;
  logic                  trig;

  logic [W-1:0]          mem_q [DEPTH];
  logic [W-1:0]          rd_data_q;

  // Stream registers and monitor pipeline
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      live_q      <= 1'b0;
      acc_q       <= '0;
      adc_data_q  <= '0;
      dac_tdata_q <= '0;
      mon_lines_q <= '0;
      mon_valid_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= adc_in_tvalid_i[c] & live_q;
        if (adc_in_tvalid_i[c] && live_q)
          adc_data_q[c*W +: W] <= adc_in_tdata_i[c*W +: W];
        // A stalled beat holds; source words arriving meanwhile are dropped.
        if (!live_q || dac_out_tready_i[c])
          dac_tdata_q[c*W +: W] <= dac_data_i[c*W +: W];
      end
      mon_lines_q <= mon_lines_d;
      mon_valid_q <= mon_valid_d;
    end
  end

  always_comb begin
    sel_eff = monitor_select_i;
    if (int'(monitor_select_i) >= NUM_CH) sel_eff = '0;
    mon_lines_d = '0;
    mon_valid_d = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_eff == SEL_W'(c)) begin
        if (monitor_source_i) begin
          mon_lines_d = dac_tdata_q[c*W +: W];
          mon_valid_d = live_q & dac_out_tready_i[c];
        end else begin
          mon_lines_d = adc_data_q[c*W +: W];
          mon_valid_d = acc_q[c];
        end
      end
    end
  end

  // Capture FSM
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    wr_en     = 1'b0;
    wr_addr   = '0;
    lane0     = mon_lines_q[SAMPLE_W-1:0];
    trig      = cap_force_i ||
                (prev_ok_q &&
                 ($signed(prev_q) < $signed(cap_threshold_i)) &&
                 ($signed(lane0) >= $signed(cap_threshold_i)));
    if (cap_arm_i) begin
      // Arm overrides everything, including a trigger in the same cycle.
      state_d   = S_ARMED;
      count_d   = '0;
      prev_ok_d = 1'b0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (mon_valid_q) begin
            if (trig) begin
              wr_en   = 1'b1;
              wr_addr = '0;
              count_d = (ADDR_W+1)'(1);
              state_d = S_CAPTURE;
            end else begin
              prev_d    = lane0;
              prev_ok_d = 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (mon_valid_q) begin
            wr_en   = 1'b1;
            wr_addr = count_q[ADDR_W-1:0];
            count_d = count_q + (ADDR_W+1)'(1);
            if (count_q == (ADDR_W+1)'(DEPTH-1)) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer has no reset; writes are blocked while reset is high so the
  // contents stay stable across a mid-capture reset.
  always_ff @(posedge clock_i) begin
    if (wr_en && !reset_i) mem_q[wr_addr] <= mon_lines_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) rd_data_q <= '0;
    else         rd_data_q <= mem_q[cap_rd_addr_i];
  end

  assign adc_in_tready_o  = {NUM_CH{live_q}};
  assign adc_data_o       = adc_data_q;
  assign dac_out_tvalid_o = {NUM_CH{live_q}};
  assign dac_out_tdata_o  = dac_tdata_q;
  assign monitor_lines_o  = mon_lines_q;
  assign cap_busy_o       = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign cap_done_o       = (state_q == S_DONE);
  assign cap_count_o      = count_q;
  assign cap_rd_data_o    = rd_data_q;

endmodule

// File: tb/tb_rf_channel_monitor.sv
module tb_rf_channel_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]    adc_tvalid, adc_tready, dac_tvalid, dac_tready;
  logic [1023:0] adc_tdata, adc_data, dac_data, dac_tdata;
  logic [2:0]    sel;
  logic          src;
  logic [127:0]  mon;
  logic          arm, frc;
  logic [15:0]   thr;
  logic          busy, done;
  logic [4:0]    cnt;
  logic [3:0]    rd_addr;
  logic [127:0]  rd_data;

  logic [5:0]    a6_tvalid, a6_tready, d6_tvalid;
  logic [767:0]  a6_tdata, a6_data, d6_tdata;
  logic [127:0]  mon6, rd6;
  logic          busy6, done6;
  logic [4:0]    cnt6;

  int total = 0;
  int bad = 0;

  rf_channel_monitor u_dut (
    .clock_i(clk), .reset_i(rst),
    .adc_in_tvalid_i(adc_tvalid), .adc_in_tdata_i(adc_tdata),
    .adc_in_tready_o(adc_tready), .adc_data_o(adc_data),
    .dac_data_i(dac_data), .dac_out_tvalid_o(dac_tvalid),
    .dac_out_tdata_o(dac_tdata), .dac_out_tready_i(dac_tready),
    .monitor_select_i(sel), .monitor_source_i(src), .monitor_lines_o(mon),
    .cap_arm_i(arm), .cap_force_i(frc), .cap_threshold_i(thr),
    .cap_busy_o(busy), .cap_done_o(done), .cap_count_o(cnt),
    .cap_rd_addr_i(rd_addr), .cap_rd_data_o(rd_data)
  );

  rf_channel_monitor #(.NUM_CH(6)) u_dut6 (
    .clock_i(clk), .reset_i(rst),
    .adc_in_tvalid_i(a6_tvalid), .adc_in_tdata_i(a6_tdata),
    .adc_in_tready_o(a6_tready), .adc_data_o(a6_data),
    .dac_data_i('0), .dac_out_tvalid_o(d6_tvalid),
    .dac_out_tdata_o(d6_tdata), .dac_out_tready_i(6'h3F),
    .monitor_select_i(sel), .monitor_source_i(src), .monitor_lines_o(mon6),
    .cap_arm_i(1'b0), .cap_force_i(1'b0), .cap_threshold_i(16'h0000),
    .cap_busy_o(busy6), .cap_done_o(done6), .cap_count_o(cnt6),
    .cap_rd_addr_i(4'h0), .cap_rd_data_o(rd6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_capture();
    adc_tvalid = 8'h00;
    repeat (3) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // lane0 of ADC ch0 ramps 0x00F0 + 8*i, one beat per cycle, then pipeline flush
  task automatic ramp(input int n);
    for (int i = 0; i < n; i++) begin
      adc_tdata[15:0] = 16'h00F0 + 16'(8 * i);
      adc_tvalid = 8'h01;
      tick();
    end
    adc_tvalid = 8'h00;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adc_tvalid = 8'hFF;
    repeat (3) tick();
    total++;
    if (adc_tready !== 8'h00 || dac_tvalid !== 8'h00) begin
      bad++; $display("FAIL reset_hold_ready got=%h/%h exp=00/00", adc_tready, dac_tvalid);
    end
    total++;
    if (adc_data !== '0 || mon !== '0 || cnt !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || rd_data !== '0) begin
      bad++; $display("FAIL reset_hold_outputs cnt=%0d busy=%b done=%b", cnt, busy, done);
    end
    rst = 1'b0;
    #1;
    total++;
    if (adc_tready !== 8'h00 || dac_tvalid !== 8'h00) begin
      bad++; $display("FAIL reset_first_cycle got=%h/%h exp=00/00", adc_tready, dac_tvalid);
    end
    tick();
    total++;
    if (adc_tready !== 8'hFF || dac_tvalid !== 8'hFF) begin
      bad++; $display("FAIL reset_second_cycle got=%h/%h exp=ff/ff", adc_tready, dac_tvalid);
    end
  endtask

  task automatic test_adc_path();
    adc_tdata[5*128 + 48 +: 16] = 16'h1234;
    sel = 3'd5;
    src = 1'b0;
    tick();
    total++;
    if (adc_data[5*128 + 48 +: 16] !== 16'h1234) begin
      bad++; $display("FAIL adc_latency got=%h exp=1234", adc_data[5*128 + 48 +: 16]);
    end
    tick();
    total++;
    if (mon[48 +: 16] !== 16'h1234) begin
      bad++; $display("FAIL mon_adc_latency got=%h exp=1234", mon[48 +: 16]);
    end
    adc_tvalid[5] = 1'b0;
    adc_tdata[5*128 + 48 +: 16] = 16'hBEEF;
    repeat (2) tick();
    total++;
    if (adc_data[5*128 + 48 +: 16] !== 16'h1234) begin
      bad++; $display("FAIL adc_hold_no_valid got=%h exp=1234", adc_data[5*128 + 48 +: 16]);
    end
    adc_tvalid = 8'hFF;
  endtask

  task automatic test_dac_stall();
    dac_data[2*128 +: 16] = 16'h0009;
    tick();
    total++;
    if (dac_tdata[2*128 +: 16] !== 16'h0009) begin
      bad++; $display("FAIL dac_load got=%h exp=0009", dac_tdata[2*128 +: 16]);
    end
    dac_tready[2] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      dac_data[2*128 +: 16] = 16'(i);
      tick();
      total++;
      if (dac_tdata[2*128 +: 16] !== 16'h0009) begin
        bad++; $display("FAIL dac_stall_hold%0d got=%h exp=0009", i, dac_tdata[2*128 +: 16]);
      end
    end
    dac_tready[2] = 1'b1;
    dac_data[2*128 +: 16] = 16'h0005;
    tick();
    total++;
    if (dac_tdata[2*128 +: 16] !== 16'h0005) begin
      bad++; $display("FAIL dac_release got=%h exp=0005", dac_tdata[2*128 +: 16]);
    end
    sel = 3'd2;
    src = 1'b1;
    tick();
    total++;
    if (mon[15:0] !== 16'h0005) begin
      bad++; $display("FAIL mon_dac got=%h exp=0005", mon[15:0]);
    end
  endtask

  task automatic test_select();
    src = 1'b0;
    adc_tdata[7*128 +: 16] = 16'h7777;
    adc_tdata[0 +: 16] = 16'h0A0A;
    a6_tdata[0 +: 16] = 16'h0A0A;
    a6_tdata[5*128 +: 16] = 16'h5555;
    sel = 3'd7;
    repeat (2) tick();
    total++;
    if (mon[15:0] !== 16'h7777) begin
      bad++; $display("FAIL select7_ch8 got=%h exp=7777", mon[15:0]);
    end
    total++;
    if (mon6[15:0] !== 16'h0A0A) begin
      bad++; $display("FAIL select7_ch6_fallback got=%h exp=0a0a", mon6[15:0]);
    end
    sel = 3'd5;
    tick();
    total++;
    if (mon6[15:0] !== 16'h5555) begin
      bad++; $display("FAIL select5_ch6 got=%h exp=5555", mon6[15:0]);
    end
    sel = 3'd0;
  endtask

  task automatic test_capture_ramp();
    thr = 16'h0100;
    arm_capture();
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || cnt !== 5'd0) begin
      bad++; $display("FAIL armed_state busy=%b done=%b cnt=%0d exp=1/0/0", busy, done, cnt);
    end
    ramp(20);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt !== 5'd16) begin
      bad++; $display("FAIL ramp_done done=%b busy=%b cnt=%0d exp=1/0/16", done, busy, cnt);
    end
    rd_addr = 4'd0;
    tick();
    total++;
    if (rd_data[15:0] !== 16'h0100) begin
      bad++; $display("FAIL ramp_addr0 got=%h exp=0100", rd_data[15:0]);
    end
    rd_addr = 4'd7;
    tick();
    total++;
    if (rd_data[15:0] !== 16'h0138) begin
      bad++; $display("FAIL ramp_addr7 got=%h exp=0138", rd_data[15:0]);
    end
    rd_addr = 4'd15;
    tick();
    total++;
    if (rd_data[15:0] !== 16'h0178) begin
      bad++; $display("FAIL ramp_addr15 got=%h exp=0178", rd_data[15:0]);
    end
  endtask

  task automatic test_force_rearm();
    arm_capture();
    frc = 1'b1;
    repeat (3) tick();
    total++;
    if (busy !== 1'b1 || cnt !== 5'd0) begin
      bad++; $display("FAIL force_no_beat busy=%b cnt=%0d exp=1/0", busy, cnt);
    end
    adc_tdata[15:0] = 16'h0042;
    adc_tvalid = 8'h01;
    tick();
    adc_tvalid = 8'h00;
    repeat (2) tick();
    total++;
    if (cnt !== 5'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL force_trigger cnt=%0d busy=%b exp=1/1", cnt, busy);
    end
    frc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adc_tdata[15:0] = 16'h0050 + 16'(i);
      adc_tvalid = 8'h01;
      tick();
    end
    adc_tvalid = 8'h00;
    repeat (3) tick();
    total++;
    if (cnt !== 5'd4) begin
      bad++; $display("FAIL capture_count got=%0d exp=4", cnt);
    end
    rd_addr = 4'd0;
    tick();
    total++;
    if (rd_data[15:0] !== 16'h0042) begin
      bad++; $display("FAIL force_addr0 got=%h exp=0042", rd_data[15:0]);
    end
    rd_addr = 4'd3;
    tick();
    total++;
    if (rd_data[15:0] !== 16'h0052) begin
      bad++; $display("FAIL force_addr3 got=%h exp=0052", rd_data[15:0]);
    end
    arm = 1'b1;
    tick();
    arm = 1'b0;
    total++;
    if (cnt !== 5'd0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL rearm cnt=%0d busy=%b done=%b exp=0/1/0", cnt, busy, done);
    end
  endtask

  task automatic test_reset_mid_capture();
    bit hit;
    hit = 1'b0;
    thr = 16'h0100;
    arm_capture();
    for (int i = 0; i < 40 && !hit; i++) begin
      adc_tdata[15:0] = 16'h00F0 + 16'(8 * i);
      adc_tvalid = 8'h01;
      tick();
      if (cnt == 5'd7) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL reach_count7 got=%0d exp=7", cnt);
    end
    rst = 1'b1;
    adc_tvalid = 8'h00;
    tick();
    total++;
    if (busy !== 1'b0 || cnt !== 5'd0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_mid busy=%b cnt=%0d done=%b exp=0/0/0", busy, cnt, done);
    end
    tick();
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if (busy !== 1'b0 || cnt !== 5'd0) begin
      bad++; $display("FAIL idle_after_reset busy=%b cnt=%0d exp=0/0", busy, cnt);
    end
    arm_capture();
    ramp(20);
    total++;
    if (done !== 1'b1 || cnt !== 5'd16) begin
      bad++; $display("FAIL recapture_done done=%b cnt=%0d exp=1/16", done, cnt);
    end
    rd_addr = 4'd15;
    tick();
    total++;
    if (rd_data[15:0] !== 16'h0178) begin
      bad++; $display("FAIL recapture_addr15 got=%h exp=0178", rd_data[15:0]);
    end
  endtask

  initial begin
    adc_tvalid = 8'hFF;
    adc_tdata  = '0;
    dac_data   = '0;
    dac_tready = 8'hFF;
    sel        = 3'd0;
    src        = 1'b0;
    arm        = 1'b0;
    frc        = 1'b0;
    thr        = 16'h0100;
    rd_addr    = 4'd0;
    a6_tvalid  = 6'h3F;
    a6_tdata   = '0;
    test_reset();
    test_adc_path();
    test_dac_stall();
    test_select();
    test_capture_ramp();
    test_force_rearm();
    test_reset_mid_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
